// File: rtl/gcd_serial_ctrl.sv
// gcd_serial_ctrl
//   Serial pad sequencer for the gcd core. An operand pair {A, B} of 2*OPW
//   bits is shifted in MSB first on ser_in, issued to the core over the
//   req valid/ready channel, and the OPW-bit response is shifted back out
//   MSB first on ser_out. Every output is a register.
//
//   Optional feature: define GCD_CTRL_TIMEOUT_EN to abort a WAIT that lasts
//   TIMEOUT_CYC cycles without a response. The abort pulses err for one
//   cycle and returns to LOAD. Without the macro, err is tied low and no
//   wait counter exists.

module gcd_serial_ctrl #(
   parameter int OPW         = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ser_in,
   input  logic             ser_in_val,
   output logic             ser_out,
   output logic             ser_out_val,
   output logic             busy,
   output logic             err,
   output logic [2*OPW-1:0] req_msg,
   output logic             req_val,
   input  logic             req_rdy,
   input  logic [OPW-1:0]   resp_msg,
   input  logic             resp_val,
   output logic             resp_rdy
);

   // The bit counter is shared: it counts up to 2*OPW input bits in LOAD
   // and up to OPW output bits in SHIFT.
   localparam int CW = $clog2(2*OPW + 1);
   localparam logic [CW-1:0] LAST_IN_BIT = CW'(2*OPW - 1);
   localparam logic [CW-1:0] OUT_BITS    = CW'(OPW);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_SHIFT = 2'd3
   } state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [2*OPW-1:0] req_msg_n;
   logic [OPW-1:0]   result, result_n;
   logic             ser_out_n;
   logic             ser_out_val_n;
   logic             req_val_n;
   logic             resp_rdy_n;
   logic             busy_n;

   // Reject parameter values that would give zero-width or meaningless counters.
   if (OPW < 2 || TIMEOUT_CYC < 1) begin : g_param_check
      $error("gcd_serial_ctrl: OPW must be >= 2 and TIMEOUT_CYC >= 1");
   end

`ifdef GCD_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] wait_cnt, wait_cnt_n;
   logic          err_q, err_n;

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // Next-state and next-register computation; every target gets a hold or
   // idle default first so that only the active state's actions override it.
   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      req_msg_n     = req_msg;
      result_n      = result;
      ser_out_n     = 1'b0;
      ser_out_val_n = 1'b0;
`ifdef GCD_CTRL_TIMEOUT_EN
      wait_cnt_n    = wait_cnt;
      err_n         = 1'b0;
`endif

      case (state)
         ST_LOAD: begin
            if (ser_in_val) begin
               req_msg_n = {req_msg[2*OPW-2:0], ser_in};
               if (cnt == LAST_IN_BIT) begin
                  cnt_n   = '0;
                  state_n = ST_ISSUE;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end

         ST_ISSUE: begin
            if (req_val && req_rdy) begin
               state_n = ST_WAIT;
`ifdef GCD_CTRL_TIMEOUT_EN
               wait_cnt_n = '0;
`endif
            end
         end

         ST_WAIT: begin
            if (resp_val && resp_rdy) begin
               ser_out_n     = resp_msg[OPW-1];
               ser_out_val_n = 1'b1;
               result_n      = {resp_msg[OPW-2:0], 1'b0};
               cnt_n         = CW'(1);
               state_n       = ST_SHIFT;
            end
`ifdef GCD_CTRL_TIMEOUT_EN
            else if (wait_cnt == LAST_WAIT) begin
               err_n    = 1'b1;
               result_n = '0;
               state_n  = ST_LOAD;
            end else begin
               wait_cnt_n = wait_cnt + TW'(1);
            end
`endif
         end

         ST_SHIFT: begin
            if (cnt == OUT_BITS) begin
               cnt_n   = '0;
               state_n = ST_LOAD;
            end else begin
               ser_out_n     = result[OPW-1];
               ser_out_val_n = 1'b1;
               result_n      = {result[OPW-2:0], 1'b0};
               cnt_n         = cnt + CW'(1);
            end
         end

         default: begin
            state_n = ST_LOAD;
            cnt_n   = '0;
         end
      endcase

      req_val_n  = (state_n == ST_ISSUE);
      resp_rdy_n = (state_n == ST_WAIT);
      busy_n     = (state_n != ST_LOAD);
   end

   // State register; reset drops any operation in progress straight back to LOAD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_LOAD;
      end else begin
         state <= state_n;
      end
   end

   // Datapath and output registers, derived from the next state so handshake
   // outputs line up with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt         <= '0;
         req_msg     <= '0;
         result      <= '0;
         ser_out     <= 1'b0;
         ser_out_val <= 1'b0;
         req_val     <= 1'b0;
         resp_rdy    <= 1'b0;
         busy        <= 1'b0;
      end else begin
         cnt         <= cnt_n;
         req_msg     <= req_msg_n;
         result      <= result_n;
         ser_out     <= ser_out_n;
         ser_out_val <= ser_out_val_n;
         req_val     <= req_val_n;
         resp_rdy    <= resp_rdy_n;
         busy        <= busy_n;
      end
   end

`ifdef GCD_CTRL_TIMEOUT_EN
   // Response watchdog: counts WAIT cycles and produces the one-cycle abort pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         wait_cnt <= wait_cnt_n;
         err_q    <= err_n;
      end
   end
`endif

endmodule

// File: tb/tb_gcd_serial_ctrl.sv
// tb_gcd_serial_ctrl
//   Directed bench for gcd_serial_ctrl. Operands are shifted in serially, a
//   small core model answers requests, and a monitor checks the issued
//   req_msg and the serialised result against queued expectations.
//   The timeout scenario is built only when GCD_CTRL_TIMEOUT_EN is defined.

module tb_gcd_serial_ctrl;

   localparam int OPW = 16;

   logic             clk;
   logic             reset;
   logic             ser_in;
   logic             ser_in_val;
   logic             ser_out;
   logic             ser_out_val;
   logic             busy;
   logic             err;
   logic [2*OPW-1:0] req_msg;
   logic             req_val;
   logic             req_rdy;
   logic [OPW-1:0]   resp_msg;
   logic             resp_val;
   logic             resp_rdy;

   int checks;
   int errors;
   int res_count;
   int core_delay;
   logic core_noresp;
   logic err_allowed;

   logic [2*OPW-1:0] exp_req_q[$];
   logic [OPW-1:0]   exp_res_q[$];

   gcd_serial_ctrl #(.OPW(OPW), .TIMEOUT_CYC(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .ser_in      (ser_in),
      .ser_in_val  (ser_in_val),
      .ser_out     (ser_out),
      .ser_out_val (ser_out_val),
      .busy        (busy),
      .err         (err),
      .req_msg     (req_msg),
      .req_val     (req_val),
      .req_rdy     (req_rdy),
      .resp_msg    (resp_msg),
      .resp_val    (resp_val),
      .resp_rdy    (resp_rdy)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case some wait was never bounded.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [OPW-1:0] gcd16(input logic [OPW-1:0] a_in, input logic [OPW-1:0] b_in);
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
      logic [OPW-1:0] t;
      a = a_in;
      b = b_in;
      for (int i = 0; i < 64; i++) begin
         if (b != '0) begin
            t = a % b;
            a = b;
            b = t;
         end
      end
      return a;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Core model: answers each accepted request with the gcd after core_delay cycles.
   initial begin
      logic [OPW-1:0] res;
      resp_val = 1'b0;
      resp_msg = '0;
      forever begin
         @(negedge clk);
         if (!reset && req_val && req_rdy && !core_noresp) begin
            res = gcd16(req_msg[2*OPW-1:OPW], req_msg[OPW-1:0]);
            @(posedge clk); #1;
            for (int d = 0; d < core_delay; d++) begin
               @(posedge clk); #1;
            end
            resp_val = 1'b1;
            resp_msg = res;
            for (int c = 0; c < 2000; c++) begin
               @(negedge clk);
               if (resp_rdy) break;
            end
            @(posedge clk); #1;
            resp_val = 1'b0;
            resp_msg = 16'hA5C3;
         end
      end
   end

   // Monitor: pops expectations at each request handshake and each completed serial result.
   initial begin
      logic [OPW-1:0] shift_acc;
      int bit_cnt;
      logic prev_resp_hs;
      shift_acc = '0;
      bit_cnt = 0;
      prev_resp_hs = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bit_cnt = 0;
            prev_resp_hs = 1'b0;
         end else begin
            if (prev_resp_hs) checkOutput("ser_out_latency", {31'd0, ser_out_val}, 32'd1);
            prev_resp_hs = resp_val && resp_rdy;
            if (req_val && req_rdy) begin
               if (exp_req_q.size() == 0) checkOutput("req_unexpected", req_msg, 32'd0);
               else checkOutput("req_msg", req_msg, exp_req_q.pop_front());
            end
            if (ser_out_val) begin
               shift_acc = {shift_acc[OPW-2:0], ser_out};
               bit_cnt++;
               if (bit_cnt == OPW) begin
                  if (exp_res_q.size() == 0) checkOutput("result_unexpected", {16'd0, shift_acc}, 32'd0);
                  else checkOutput("result", {16'd0, shift_acc}, {16'd0, exp_res_q.pop_front()});
                  bit_cnt = 0;
                  res_count++;
               end
            end else if (bit_cnt != 0) begin
               checkOutput("ser_out_val_contiguous", bit_cnt, OPW);
               bit_cnt = 0;
            end
            if (err && !err_allowed) checkOutput("err_unexpected", {31'd0, err}, 32'd0);
         end
      end
   end

   // Drive 2*OPW operand bits MSB first with optional idle gaps and check req_val latency.
   task automatic shiftOperands(input logic [2*OPW-1:0] ops, input int max_gap);
      logic [2*OPW-1:0] v;
      int gap;
      v = ops;
      for (int i = 2*OPW-1; i >= 0; i--) begin
         gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
         for (int g = 0; g < gap; g++) begin
            ser_in_val = 1'b0;
            ser_in = $urandom_range(0, 1);
            @(posedge clk); #1;
         end
         ser_in = v[i];
         ser_in_val = 1'b1;
         if (i == 0) checkOutput("req_val_before_last", {31'd0, req_val}, 32'd0);
         @(posedge clk); #1;
      end
      ser_in_val = 1'b0;
      checkOutput("req_val_latency", {31'd0, req_val}, 32'd1);
      checkOutput("busy_issue", {31'd0, busy}, 32'd1);
   endtask

   // One full transaction: shift in, optional ISSUE stall, wait for the result to drain.
   task automatic applyStimulus(input logic [2*OPW-1:0] ops, input int max_gap, input logic [OPW-1:0] exp_res,
                                input int hold_cycles, input logic toggle_in, input int delay);
      int start;
      logic done;
      start = res_count;
      core_delay = delay;
      exp_req_q.push_back(ops);
      exp_res_q.push_back(exp_res);
      req_rdy = (hold_cycles == 0);
      shiftOperands(ops, max_gap);
      for (int h = 0; h < hold_cycles; h++) begin
         checkOutput("req_val_held", {31'd0, req_val}, 32'd1);
         checkOutput("req_msg_stable", req_msg, ops);
         @(posedge clk); #1;
      end
      req_rdy = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (res_count != start) begin
            done = 1'b1;
            break;
         end
         if (toggle_in) begin
            ser_in_val = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            ser_in = $urandom_range(0, 1);
         end
         @(posedge clk); #1;
      end
      ser_in_val = 1'b0;
      checkOutput("result_done", {31'd0, done}, 32'd1);
      checkOutput("busy_after", {31'd0, busy}, 32'd0);
      checkOutput("ser_out_idle", {30'd0, ser_out_val, ser_out}, 32'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_msg"}, req_msg, 32'd0);
      checkOutput({tag, "_flags"}, {26'd0, req_val, resp_rdy, ser_out, ser_out_val, busy, err}, 32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      res_count = 0;
      core_delay = 2;
      core_noresp = 1'b0;
      err_allowed = 1'b0;
      reset = 1'b1;
      ser_in = 1'b0;
      ser_in_val = 1'b0;
      req_rdy = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      checkResetOutputs("reset_init");
      reset = 1'b0;
      @(posedge clk); #1;

      $display("[TB] back-to-back shift of 0x000C0008");
      applyStimulus(32'h000C_0008, 0, 16'h0004, 0, 1'b0, 2);

      $display("[TB] same operands with idle gaps and a slow core");
      applyStimulus(32'h000C_0008, 3, 16'h0004, 0, 1'b0, 40);

      $display("[TB] ISSUE stall with req_rdy low for 5 cycles");
      applyStimulus(32'h0009_0006, 0, 16'h0003, 5, 1'b0, 1);

      $display("[TB] reset after 10 accepted bits");
      for (int i = 0; i < 10; i++) begin
         ser_in = 1'b1;
         ser_in_val = 1'b1;
         @(posedge clk); #1;
      end
      ser_in_val = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      checkResetOutputs("reset_mid");
      repeat (2) @(posedge clk);
      #1;
      checkResetOutputs("reset_hold");
      reset = 1'b0;
      applyStimulus(32'h0015_000E, 0, 16'h0007, 0, 1'b0, 0);

      $display("[TB] ser_in_val toggling during WAIT and SHIFT");
      applyStimulus(32'h0030_0012, 0, 16'h0006, 0, 1'b1, 6);
      applyStimulus(32'hFFFF_FFFF, 1, 16'hFFFF, 0, 1'b0, 3);
      applyStimulus(32'h8000_0001, 0, 16'h0001, 0, 1'b0, 0);

`ifdef GCD_CTRL_TIMEOUT_EN
      $display("[TB] response timeout with silent core");
      core_noresp = 1'b1;
      err_allowed = 1'b1;
      exp_req_q.push_back(32'h000C_0008);
      req_rdy = 1'b1;
      shiftOperands(32'h000C_0008, 0);
      @(posedge clk); #1;
      for (int w = 0; w < 16; w++) begin
         checkOutput("timeout_wait_err", {31'd0, err}, 32'd0);
         checkOutput("timeout_wait_rdy", {31'd0, resp_rdy}, 32'd1);
         @(posedge clk); #1;
      end
      checkOutput("timeout_err", {31'd0, err}, 32'd1);
      checkOutput("timeout_state", {30'd0, busy, resp_rdy}, 32'd0);
      @(posedge clk); #1;
      checkOutput("timeout_err_pulse", {31'd0, err}, 32'd0);
      checkOutput("timeout_no_ser_out", {31'd0, ser_out_val}, 32'd0);
      err_allowed = 1'b0;
      core_noresp = 1'b0;
      applyStimulus(32'h0015_000E, 0, 16'h0007, 0, 1'b0, 0);
`endif

      repeat (3) @(posedge clk);
      #1;
      checkOutput("req_queue_empty", exp_req_q.size(), 32'd0);
      checkOutput("res_queue_empty", exp_res_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
